md4_stage2_inv: RTL and testbench

- Iterative inverse of the MD4 round-2 datapath.
- Given the round-2 output state (a,b,c,d) and the same 512-bit message block, recovers the round-2 input state by undoing the 16 round-2 steps in reverse order, one step per clock.
- Sits beside the combinational round-2 stage. Used for round-trip checking of the forward stage and as the backward half of the MD4 analysis path.

---
 rtl/md4_pkg.sv | 43 ++++
 rtl/md4_stage2_inv_if.sv | 26 ++
 rtl/md4_inv_step.sv | 19 +
 rtl/md4_stage2_inv.sv | 136 +++++++++++++
 tb/tb_md4_stage2_inv.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/md4_pkg.sv
// Shared MD4 round-2 constants, step tables and word functions.
// Used by both the inverse stage and its single-step datapath.
package md4_pkg;

  localparam logic [31:0] K2 = 32'h5A82_7999;

  localparam logic [4:0] R2_SHIFT [4] = '{5'd3, 5'd5, 5'd9, 5'd13};

  localparam logic [3:0] R2_MSG_IDX [16] = '{
    4'd0, 4'd4, 4'd8,  4'd12,
    4'd1, 4'd5, 4'd9,  4'd13,
    4'd2, 4'd6, 4'd10, 4'd14,
    4'd3, 4'd7, 4'd11, 4'd15
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Majority function used by every round-2 step.
  function automatic logic [31:0] g_fn(input logic [31:0] p,
                                       input logic [31:0] q,
                                       input logic [31:0] r);
    return (p & q) | (p & r) | (q & r);
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] v,
                                         input logic [4:0]  s);
    logic [63:0] t;
    t = {v, v} << s;
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] v,
                                         input logic [4:0]  s);
    logic [63:0] t;
    t = {v, v} >> s;
    return t[31:0];
  endfunction

endpackage

// File: rtl/md4_stage2_inv_if.sv
// Request/result bundle of the round-2 inverse: start plus operands in,
// status and recovered state out.
interface md4_stage2_inv_if;
  logic         start;
  logic [31:0]  in_a;
  logic [31:0]  in_b;
  logic [31:0]  in_c;
  logic [31:0]  in_d;
  logic [511:0] x;
  logic         busy;
  logic         done;
  logic [31:0]  out_a;
  logic [31:0]  out_b;
  logic [31:0]  out_c;
  logic [31:0]  out_d;

  modport master (
    output start, in_a, in_b, in_c, in_d, x,
    input  busy, done, out_a, out_b, out_c, out_d
  );

  modport slave (
    input  start, in_a, in_b, in_c, in_d, x,
    output busy, done, out_a, out_b, out_c, out_d
  );
endinterface

// File: rtl/md4_inv_step.sv
// One inverse round-2 step: undoes target = ROTL(target + G + X[k] + K, s).
// Purely combinational.
module md4_inv_step
  import md4_pkg::*;
#(
  parameter logic [31:0] K = K2
) (
  input  logic [31:0] target,
  input  logic [31:0] p,
  input  logic [31:0] q,
  input  logic [31:0] r,
  input  logic [31:0] xk,
  input  logic [4:0]  s,
  output logic [31:0] word
);

  assign word = rotr32(target, s) - g_fn(p, q, r) - xk - K;

endmodule

// File: rtl/md4_stage2_inv.sv
// Iterative MD4 round-2 inverse: replays steps 15..0 backwards, one per clock.
// Start accepted at edge T gives done in the cycle after edge T+16.
module md4_stage2_inv
  import md4_pkg::*;
#(
  parameter logic [31:0] K2_VAL = K2
) (
  input  logic            clk,
  input  logic            rst_n,
  md4_stage2_inv_if.slave bus
);

  state_e       state_q;
  state_e       state_d;
  logic         load;
  logic         step_en;
  logic [3:0]   step_q;
  logic [31:0]  a_q;
  logic [31:0]  b_q;
  logic [31:0]  c_q;
  logic [31:0]  d_q;
  logic [511:0] msg_q;

  logic [31:0]  tgt;
  logic [31:0]  op_p;
  logic [31:0]  op_q;
  logic [31:0]  op_r;
  logic [31:0]  xk;
  logic [31:0]  word;
  logic [4:0]   shamt;
  logic [3:0]   k_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE accepts a new start just like IDLE, so back-to-back ops have no bubble.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step_en  = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        step_en  = 1'b1;
        if (step_q == 4'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Target rotates a, d, c, b; operands follow the forward G argument order.
  always_comb begin
    tgt  = a_q;
    op_p = b_q;
    op_q = c_q;
    op_r = d_q;
    case (step_q[1:0])
      2'd0: begin tgt = a_q; op_p = b_q; op_q = c_q; op_r = d_q; end
      2'd1: begin tgt = d_q; op_p = a_q; op_q = b_q; op_r = c_q; end
      2'd2: begin tgt = c_q; op_p = d_q; op_q = a_q; op_r = b_q; end
      default: begin tgt = b_q; op_p = c_q; op_q = d_q; op_r = a_q; end
    endcase
  end

  assign k_idx = R2_MSG_IDX[step_q];
  assign shamt = R2_SHIFT[step_q[1:0]];
  assign xk    = msg_q[{k_idx, 5'd0} +: 32];

  md4_inv_step #(
    .K (K2_VAL)
  ) u_step (
    .target (tgt),
    .p      (op_p),
    .q      (op_q),
    .r      (op_r),
    .xk     (xk),
    .s      (shamt),
    .word   (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q <= 4'd0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      msg_q  <= '0;
    end else if (load) begin
      step_q <= 4'd15;
      a_q    <= bus.in_a;
      b_q    <= bus.in_b;
      c_q    <= bus.in_c;
      d_q    <= bus.in_d;
      msg_q  <= bus.x;
    end else if (step_en) begin
      step_q <= step_q - 4'd1;
      case (step_q[1:0])
        2'd0:    a_q <= word;
        2'd1:    d_q <= word;
        2'd2:    c_q <= word;
        default: b_q <= word;
      endcase
    end
  end

  assign bus.out_a = a_q;
  assign bus.out_b = b_q;
  assign bus.out_c = c_q;
  assign bus.out_d = d_q;

endmodule

// File: tb/tb_md4_stage2_inv.sv
// Round-trip bench: a forward MD4 round-2 model feeds the inverse, which must
// return the original state; plus latency, restart, back-to-back and reset cases.
module tb_md4_stage2_inv;

  localparam logic [31:0] TB_K2 = 32'h5A827999;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  md4_stage2_inv_if ifc ();

  md4_stage2_inv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [127:0] orig;
    logic [511:0] m;
    logic [127:0] fin;
  } vec_t;

  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] v, input int s);
    return (v >> s) | (v << (32 - s));
  endfunction

  function automatic logic [31:0] gm(input logic [31:0] p, q, r);
    return (p & q) | (p & r) | (q & r);
  endfunction

  function automatic logic [31:0] wd(input logic [511:0] m, input int k);
    return m[32*k +: 32];
  endfunction

  // Classic MD4 round 2 written in the forward direction.
  function automatic logic [127:0] fwd(input logic [127:0] st, input logic [511:0] m);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = st;
    for (int j = 0; j < 4; j++) begin
      a = rl(a + gm(b, c, d) + wd(m, j)      + TB_K2, 3);
      d = rl(d + gm(a, b, c) + wd(m, j + 4)  + TB_K2, 5);
      c = rl(c + gm(d, a, b) + wd(m, j + 8)  + TB_K2, 9);
      b = rl(b + gm(c, d, a) + wd(m, j + 12) + TB_K2, 13);
    end
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] rand_msg();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [127:0] rand_st();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {ifc.out_a, ifc.out_b, ifc.out_c, ifc.out_d};
  endfunction

  // Present operands with start at a negedge; returns #1 after the accepting edge.
  task automatic launch(input logic [127:0] fin, input logic [511:0] m, input bit hold);
    @(negedge clk);
    {ifc.in_a, ifc.in_b, ifc.in_c, ifc.in_d} = fin;
    ifc.x     = m;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) ifc.start = 1'b0;
  endtask

  task automatic wait_done(inout int cnt, inout int busy_cnt);
    while (!ifc.done && cnt < 40) begin
      if (ifc.busy) busy_cnt++;
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  vec_t         tbl [4];
  logic [127:0] st_a, st_b, fin_a, fin_b, res;
  logic [511:0] m_a, m_b;
  int           lat, bcnt;

  initial begin
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    ifc.start   = 1'b0;
    ifc.in_a    = '0;
    ifc.in_b    = '0;
    ifc.in_c    = '0;
    ifc.in_d    = '0;
    ifc.x       = '0;

    tbl[0].orig = {32'h9cf79903, 32'h6472bcbb, 32'h073a3859, 32'h17ea3e30};
    tbl[0].m    = '0;
    tbl[0].m[511:480] = 32'h50535554;
    tbl[0].m[479:448] = 32'h80000000;
    tbl[0].m[31:0]    = 32'h00000020;
    tbl[1].orig = '0;
    tbl[1].m    = '0;
    tbl[2].orig = '1;
    tbl[2].m    = '1;
    tbl[3].orig = {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
    for (int i = 0; i < 16; i++) tbl[3].m[32*i +: 32] = 32'h1111_1111 * (i + 1);
    for (int i = 0; i < 4; i++) tbl[i].fin = fwd(tbl[i].orig, tbl[i].m);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 128'd0);
    chk("reset_flags", {126'd0, ifc.busy, ifc.done}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: result, latency and busy length.
    for (int i = 0; i < 4; i++) begin
      launch(tbl[i].fin, tbl[i].m, 1'b0);
      lat = 0; bcnt = 0;
      wait_done(lat, bcnt);
      chk($sformatf("tbl%0d_result", i), outs(), tbl[i].orig);
      chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'd16);
      chk($sformatf("tbl%0d_busy", i), 128'(bcnt), 128'd16);
    end

    // Output holds after DONE.
    @(posedge clk); #1;
    chk("hold_after_done", outs(), tbl[3].orig);
    chk("idle_after_done", {126'd0, ifc.busy, ifc.done}, 128'd0);

    // Randomized round trips.
    for (int i = 0; i < 100; i++) begin
      st_a = rand_st();
      m_a  = rand_msg();
      launch(fwd(st_a, m_a), m_a, 1'b0);
      lat = 0; bcnt = 0;
      wait_done(lat, bcnt);
      chk($sformatf("rand%0d", i), outs(), st_a);
    end

    // Single step: first RUN edge undoes step 15, which targets b.
    st_a = rand_st(); m_a = rand_msg(); fin_a = fwd(st_a, m_a);
    launch(fin_a, m_a, 1'b0);
    @(posedge clk); #1;
    chk("single_step15", outs(),
        {fin_a[127:96],
         rr(fin_a[95:64], 13) - gm(fin_a[63:32], fin_a[31:0], fin_a[127:96])
           - m_a[511:480] - TB_K2,
         fin_a[63:32], fin_a[31:0]});
    lat = 1; bcnt = 0;
    wait_done(lat, bcnt);
    chk("single_step_final", outs(), st_a);

    // Start during RUN is ignored.
    st_a = rand_st(); m_a = rand_msg(); fin_a = fwd(st_a, m_a);
    st_b = rand_st(); m_b = rand_msg(); fin_b = fwd(st_b, m_b);
    launch(fin_a, m_a, 1'b0);
    lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    {ifc.in_a, ifc.in_b, ifc.in_c, ifc.in_d} = fin_b;
    ifc.x     = m_b;
    ifc.start = 1'b1;
    @(posedge clk); #1; lat++;
    ifc.start = 1'b0;
    bcnt = 0;
    wait_done(lat, bcnt);
    chk("run_start_latency", 128'(lat), 128'd16);
    chk("run_start_result", outs(), st_a);
    @(posedge clk); #1;
    chk("run_start_no_restart", {127'd0, ifc.busy}, 128'd0);

    // Back-to-back with start held high.
    launch(fin_a, m_a, 1'b1);
    {ifc.in_a, ifc.in_b, ifc.in_c, ifc.in_d} = fin_b;
    ifc.x = m_b;
    lat = 0; bcnt = 0;
    wait_done(lat, bcnt);
    chk("b2b_first_latency", 128'(lat), 128'd16);
    chk("b2b_first_result", outs(), st_a);
    @(posedge clk); #1;
    lat = 1; bcnt = 0;
    wait_done(lat, bcnt);
    ifc.start = 1'b0;
    chk("b2b_period", 128'(lat), 128'd17);
    chk("b2b_second_result", outs(), st_b);
    @(posedge clk); #1;

    // Reset mid-operation, then a clean run.
    launch(fin_a, m_a, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_outs", outs(), 128'd0);
    chk("midrst_flags", {126'd0, ifc.busy, ifc.done}, 128'd0);
    @(posedge clk); #1;
    chk("midrst_stays_idle", {126'd0, ifc.busy, ifc.done}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(fin_b, m_b, 1'b0);
    lat = 0; bcnt = 0;
    wait_done(lat, bcnt);
    chk("post_rst_latency", 128'(lat), 128'd16);
    chk("post_rst_result", outs(), st_b);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
